// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART MMIO peripheral and its RX FIFO.
// Contents: register offsets inside the 16-byte window, STATUS bit positions,
// TX/RX FSM state encodings, and a helper that assembles the STATUS word.
package uart_pkg;

    // Register offsets, compared against ADDR[3:0]
    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_RXDATA = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;

    // STATUS bit positions
    localparam int STAT_TX_BUSY   = 0;
    localparam int STAT_RX_EMPTY  = 1;
    localparam int STAT_RX_FULL   = 2;
    localparam int STAT_OVERRUN   = 3;
    localparam int STAT_FRAME_ERR = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Assemble the STATUS word; unused bits read as zero
    function automatic logic [31:0] status_word(
        input logic tx_busy,
        input logic rx_empty,
        input logic rx_full,
        input logic overrun,
        input logic frame_err
    );
        logic [31:0] w;
        w                 = 32'h0000_0000;
        w[STAT_TX_BUSY]   = tx_busy;
        w[STAT_RX_EMPTY]  = rx_empty;
        w[STAT_RX_FULL]   = rx_full;
        w[STAT_OVERRUN]   = overrun;
        w[STAT_FRAME_ERR] = frame_err;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO for received UART data with a sticky overrun flag.
// Ports:
//   clk, reset      - system clock, asynchronous active-high reset
//   push, push_data - write a received byte
//   pop             - remove the head entry (ignored when empty)
//   clr_overrun     - clear the sticky overrun flag (a same-cycle drop wins)
//   head            - current head entry (undefined content when empty)
//   full, empty     - occupancy flags
//   overrun         - sticky: a push was dropped because the FIFO was full
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    input  logic       clr_overrun,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic       overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          overrun_r;
    logic          do_pop_s;
    logic          do_push_s;
    logic          drop_s;

    assign empty = (count_r == {(AW + 1){1'b0}});
    assign full  = (count_r == FULL_COUNT);
    assign head  = mem_r[rd_ptr_r];
    assign overrun = overrun_r;

    // A pop frees a slot in the same cycle, so push-while-full is legal with a pop
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign drop_s    = push & full & ~do_pop_s;

    // Storage array write port
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1'b1);
                2'b01:   count_r <= count_r - (AW + 1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overrun flag; a drop in the same cycle beats the clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (clr_overrun) begin
            overrun_r <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with TX holding register and RX FIFO.
// Ports:
//   clk, reset - system clock, asynchronous active-high reset
//   WE         - store strobe (any nonzero value stores WD[7:0])
//   RE         - load strobe; a load of RXDATA pops the RX FIFO
//   ADDR, WD   - byte address and store data
//   RD         - combinational read data (0 outside the window)
//   sel        - combinational window hit, ADDR[31:4] == BASE_ADDR[31:4]
//   tx         - serial output, idle high
//   rx         - serial input, asynchronous to clk
module uart_mmio
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 10416,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
    parameter int          RX_DEPTH     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  WE,
    input  logic        RE,
    input  logic [31:0] ADDR,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        sel,
    output logic        tx,
    input  logic        rx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int HALF  = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    // ---------------- register decode ----------------
    logic [3:0] offset_s;
    logic       store_s;
    logic       tx_store_s;
    logic       status_store_s;
    logic       pop_s;
    logic       wd_unused_s;

    assign offset_s       = ADDR[3:0];
    assign sel            = (ADDR[31:4] == BASE_ADDR[31:4]);
    assign store_s        = sel & (WE != 2'b00);
    assign tx_store_s     = store_s & (offset_s == OFF_TXDATA);
    assign status_store_s = store_s & (offset_s == OFF_STATUS);
    assign pop_s          = RE & sel & (offset_s == OFF_RXDATA);
    assign wd_unused_s    = ^WD[31:8];

    // ---------------- transmitter ----------------
    tx_state_t        tx_state_r, tx_state_next_s;
    logic [CNT_W-1:0] tx_cnt_r, tx_cnt_next_s;
    logic [2:0]       tx_bit_r, tx_bit_next_s;
    logic [7:0]       tx_data_r, tx_data_next_s;
    logic             tx_r, tx_next_s;
    logic             tx_busy_s;

    assign tx_busy_s = (tx_state_r != TX_IDLE);
    assign tx        = tx_r;

    // TX state register; tx is registered so it lines up with the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= CNT_ZERO;
            tx_bit_r   <= 3'd0;
            tx_data_r  <= 8'h00;
            tx_r       <= 1'b1;
        end else begin
            tx_state_r <= tx_state_next_s;
            tx_cnt_r   <= tx_cnt_next_s;
            tx_bit_r   <= tx_bit_next_s;
            tx_data_r  <= tx_data_next_s;
            tx_r       <= tx_next_s;
        end
    end

    // TX next-state: stores are only accepted in IDLE, so busy stores vanish
    always_comb begin
        tx_state_next_s = tx_state_r;
        tx_cnt_next_s   = tx_cnt_r;
        tx_bit_next_s   = tx_bit_r;
        tx_data_next_s  = tx_data_r;
        case (tx_state_r)
            TX_IDLE: begin
                if (tx_store_s) begin
                    tx_state_next_s = TX_START;
                    tx_cnt_next_s   = CNT_ZERO;
                    tx_bit_next_s   = 3'd0;
                    tx_data_next_s  = WD[7:0];
                end else begin
                    tx_state_next_s = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_state_next_s = TX_DATA;
                    tx_cnt_next_s   = CNT_ZERO;
                    tx_bit_next_s   = 3'd0;
                end else begin
                    tx_cnt_next_s = tx_cnt_r + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_next_s = CNT_ZERO;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_next_s = TX_STOP;
                    end else begin
                        tx_bit_next_s = tx_bit_r + 3'd1;
                    end
                end else begin
                    tx_cnt_next_s = tx_cnt_r + CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_state_next_s = TX_IDLE;
                    tx_cnt_next_s   = CNT_ZERO;
                end else begin
                    tx_cnt_next_s = tx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                tx_state_next_s = TX_IDLE;
                tx_cnt_next_s   = CNT_ZERO;
                tx_bit_next_s   = 3'd0;
            end
        endcase
    end

    // TX output: line level for the state being entered
    always_comb begin
        tx_next_s = 1'b1;
        case (tx_state_next_s)
            TX_IDLE:  tx_next_s = 1'b1;
            TX_START: tx_next_s = 1'b0;
            TX_DATA:  tx_next_s = tx_data_next_s[tx_bit_next_s];
            TX_STOP:  tx_next_s = 1'b1;
            default:  tx_next_s = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    logic             rx_meta_r, rx_sync_r;
    rx_state_t        rx_state_r, rx_state_next_s;
    logic [CNT_W-1:0] rx_cnt_r, rx_cnt_next_s;
    logic [2:0]       rx_bit_r, rx_bit_next_s;
    logic [7:0]       rx_shift_r, rx_shift_next_s;
    logic             rx_push_s;
    logic             rx_ferr_s;
    logic             frame_err_r;

    // Two-flop synchronizer for the asynchronous serial input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // RX state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= CNT_ZERO;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            rx_state_r <= rx_state_next_s;
            rx_cnt_r   <= rx_cnt_next_s;
            rx_bit_r   <= rx_bit_next_s;
            rx_shift_r <= rx_shift_next_s;
        end
    end

    // RX next-state: half-bit check in START puts later samples mid-bit
    always_comb begin
        rx_state_next_s = rx_state_r;
        rx_cnt_next_s   = rx_cnt_r;
        rx_bit_next_s   = rx_bit_r;
        rx_shift_next_s = rx_shift_r;
        case (rx_state_r)
            RX_IDLE: begin
                if (!rx_sync_r) begin
                    rx_state_next_s = RX_START;
                    rx_cnt_next_s   = CNT_ZERO;
                end else begin
                    rx_state_next_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r == HALF_LAST) begin
                    rx_cnt_next_s = CNT_ZERO;
                    rx_bit_next_s = 3'd0;
                    if (!rx_sync_r) begin
                        rx_state_next_s = RX_DATA;
                    end else begin
                        rx_state_next_s = RX_IDLE;
                    end
                end else begin
                    rx_cnt_next_s = rx_cnt_r + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_next_s   = CNT_ZERO;
                    rx_shift_next_s = {rx_sync_r, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) begin
                        rx_state_next_s = RX_STOP;
                    end else begin
                        rx_bit_next_s = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_next_s = rx_cnt_r + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_state_next_s = RX_IDLE;
                    rx_cnt_next_s   = CNT_ZERO;
                end else begin
                    rx_cnt_next_s = rx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                rx_state_next_s = RX_IDLE;
                rx_cnt_next_s   = CNT_ZERO;
                rx_bit_next_s   = 3'd0;
            end
        endcase
    end

    // RX outputs: the stop-bit sample either delivers the byte or flags a framing error
    always_comb begin
        rx_push_s = 1'b0;
        rx_ferr_s = 1'b0;
        case (rx_state_r)
            RX_STOP: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_push_s = rx_sync_r;
                    rx_ferr_s = ~rx_sync_r;
                end else begin
                    rx_push_s = 1'b0;
                    rx_ferr_s = 1'b0;
                end
            end
            default: begin
                rx_push_s = 1'b0;
                rx_ferr_s = 1'b0;
            end
        endcase
    end

    // Sticky framing-error flag; a new error beats a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err_r <= 1'b0;
        end else if (rx_ferr_s) begin
            frame_err_r <= 1'b1;
        end else if (status_store_s && WD[STAT_FRAME_ERR]) begin
            frame_err_r <= 1'b0;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0] fifo_head_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;
    logic       fifo_overrun_s;

    uart_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (rx_push_s),
        .push_data   (rx_shift_r),
        .pop         (pop_s),
        .clr_overrun (status_store_s & WD[STAT_OVERRUN]),
        .head        (fifo_head_s),
        .full        (fifo_full_s),
        .empty       (fifo_empty_s),
        .overrun     (fifo_overrun_s)
    );

    // ---------------- read mux ----------------
    // Read data mux; empty RXDATA reads zero rather than stale storage
    always_comb begin
        RD = 32'h0000_0000;
        if (sel) begin
            case (offset_s)
                OFF_RXDATA: begin
                    if (fifo_empty_s) begin
                        RD = 32'h0000_0000;
                    end else begin
                        RD = {24'h00_0000, fifo_head_s};
                    end
                end
                OFF_STATUS: RD = status_word(tx_busy_s, fifo_empty_s, fifo_full_s,
                                             fifo_overrun_s, frame_err_r);
                default:    RD = 32'h0000_0000;
            endcase
        end else begin
            RD = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: self-checking bench for uart_mmio with CLKS_PER_BIT = 4.
// Directed scenarios plus a randomized run scored against a queue-based
// model of the FIFO and sticky flags.
module tb_uart_mmio;

    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'h0000_0400;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_RX = BASE + 32'h4;
    localparam logic [31:0] A_ST = BASE + 32'h8;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  WE;
    logic        RE;
    logic [31:0] ADDR;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        sel;
    logic        tx;
    logic        rx;

    int pass_count  = 0;
    int check_count = 0;

    // Reference model: received bytes awaiting a load, and sticky flags
    logic [7:0] model_q[$];
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;

    always #5 clk = ~clk;

    uart_mmio #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .RX_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .WE(WE), .RE(RE), .ADDR(ADDR), .WD(WD),
        .RD(RD), .sel(sel), .tx(tx), .rx(rx)
    );

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s    = 32'h0;
        s[1] = (model_q.size() == 0);
        s[2] = (model_q.size() == 16);
        s[3] = m_ovr;
        s[4] = m_ferr;
        return s;
    endfunction

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        ADDR = addr; WD = data; WE = 2'($urandom_range(1, 3));
        @(negedge clk);
        WE = 2'b00; ADDR = 32'h0; WD = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        ADDR = addr; RE = 1'b1;
        #1 data = RD;
        @(negedge clk);
        RE = 1'b0; ADDR = 32'h0;
    endtask

    // Drive one 8N1 frame; optionally load RXDATA on the cycle the stop bit is sampled
    task automatic send_rx_frame(input logic [7:0] b, input logic stop_ok,
                                 input logic pop_at_stop, output logic [31:0] popped);
        popped = 32'h0;
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (pop_at_stop) begin
            ADDR = A_RX; RE = 1'b1;
            #1 popped = RD;
            @(negedge clk);
            RE = 1'b0; ADDR = 32'h0;
        end
        repeat (6) @(negedge clk);
    endtask

    // Store a byte and watch tx and STATUS[0] through the whole frame
    task automatic run_tx_frame(input logic [7:0] b, input logic inject);
        logic e;
        int   lows;
        bus_write(A_TX, {24'h0, b});
        for (int i = 0; i < 10 * CPB; i++) begin
            if (inject && i == 10) begin
                WE = 2'b10; ADDR = A_TX; WD = 32'h0000_003C;
            end else begin
                ADDR = A_ST;
            end
            #1;
            if (i < CPB)          e = 1'b0;
            else if (i < 9 * CPB) e = b[(i - CPB) / CPB];
            else                  e = 1'b1;
            check_count++;
            if (tx !== e) $display("FAIL tx_bit[%0d] byte=%h got=%b want=%b", i, b, tx, e);
            else pass_count++;
            if (!(inject && i == 10)) begin
                check_count++;
                if (RD[0] !== 1'b1) $display("FAIL tx_busy_in_frame[%0d] got=%b want=1", i, RD[0]);
                else pass_count++;
            end
            @(negedge clk);
            WE = 2'b00;
        end
        ADDR = A_ST;
        #1;
        check_count++;
        if ({tx, RD[0]} !== 2'b10) $display("FAIL tx_after_frame got tx=%b busy=%b want tx=1 busy=0", tx, RD[0]);
        else pass_count++;
        if (inject) begin
            lows = 0;
            repeat (12 * CPB) begin
                @(negedge clk);
                #1 if (tx !== 1'b1 || RD[0] !== 1'b0) lows++;
            end
            check_count++;
            if (lows != 0) $display("FAIL tx_no_second_frame got=%0d active cycles want=0", lows);
            else pass_count++;
        end
        ADDR = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1; WE = 2'b00; RE = 1'b0; ADDR = 32'h0; WD = 32'h0; rx = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_count++;
        if (tx !== 1'b1) $display("FAIL reset_tx got=%b want=1", tx); else pass_count++;
        ADDR = A_ST; #1;
        check_count++;
        if (RD !== 32'h2) $display("FAIL reset_status got=%h want=00000002", RD); else pass_count++;
        check_count++;
        if (sel !== 1'b1) $display("FAIL sel_hit got=%b want=1", sel); else pass_count++;
        ADDR = A_RX; #1;
        check_count++;
        if (RD !== 32'h0) $display("FAIL rx_empty_read got=%h want=0", RD); else pass_count++;
        ADDR = BASE + 32'hC; #1;
        check_count++;
        if (RD !== 32'h0) $display("FAIL unmapped_offset got=%h want=0", RD); else pass_count++;
        ADDR = A_ST + 32'h10; #1;
        check_count++;
        if ({sel, RD} !== 33'h0) $display("FAIL sel_miss got sel=%b rd=%h want 0/0", sel, RD); else pass_count++;
        ADDR = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_tx_frame();
        run_tx_frame(8'hA5, 1'b0);
    endtask

    task automatic test_tx_drop();
        run_tx_frame(8'hC3, 1'b1);
    endtask

    task automatic test_rx_roundtrip();
        logic [31:0] d;
        send_rx_frame(8'h5A, 1'b1, 1'b0, d);
        bus_read(A_ST, d);
        check_count++;
        if (d[1] !== 1'b0) $display("FAIL rt_not_empty got=%h want bit1=0", d); else pass_count++;
        bus_read(A_RX, d);
        check_count++;
        if (d !== 32'h5A) $display("FAIL rt_data got=%h want=0000005a", d); else pass_count++;
        bus_read(A_ST, d);
        check_count++;
        if (d !== 32'h2) $display("FAIL rt_empty_after got=%h want=00000002", d); else pass_count++;
    endtask

    task automatic test_overflow();
        logic [7:0]  bytes[17];
        logic [31:0] d;
        for (int i = 0; i < 17; i++) begin
            bytes[i] = 8'($urandom);
            send_rx_frame(bytes[i], 1'b1, 1'b0, d);
        end
        bus_read(A_ST, d);
        check_count++;
        if (d !== 32'hC) $display("FAIL ovf_status got=%h want=0000000c", d); else pass_count++;
        for (int i = 0; i < 16; i++) begin
            bus_read(A_RX, d);
            check_count++;
            if (d !== {24'h0, bytes[i]}) $display("FAIL ovf_data[%0d] got=%h want=%h", i, d, bytes[i]);
            else pass_count++;
        end
        bus_read(A_ST, d);
        check_count++;
        if (d !== 32'hA) $display("FAIL ovf_drained got=%h want=0000000a", d); else pass_count++;
        bus_write(A_ST, 32'h08);
        bus_read(A_ST, d);
        check_count++;
        if (d !== 32'h2) $display("FAIL ovf_clear got=%h want=00000002", d); else pass_count++;
    endtask

    task automatic test_push_pop_full();
        logic [7:0]  bytes[17];
        logic [31:0] d;
        for (int i = 0; i < 16; i++) begin
            bytes[i] = 8'($urandom);
            send_rx_frame(bytes[i], 1'b1, 1'b0, d);
        end
        bytes[16] = 8'($urandom);
        send_rx_frame(bytes[16], 1'b1, 1'b1, d);
        check_count++;
        if (d !== {24'h0, bytes[0]}) $display("FAIL full_pop_head got=%h want=%h", d, bytes[0]); else pass_count++;
        bus_read(A_ST, d);
        check_count++;
        if (d !== 32'h4) $display("FAIL full_pushpop_status got=%h want=00000004", d); else pass_count++;
        for (int i = 1; i < 17; i++) begin
            bus_read(A_RX, d);
            check_count++;
            if (d !== {24'h0, bytes[i]}) $display("FAIL full_pushpop_data[%0d] got=%h want=%h", i, d, bytes[i]);
            else pass_count++;
        end
    endtask

    task automatic test_frame_err();
        logic [31:0] d;
        send_rx_frame(8'h77, 1'b0, 1'b0, d);
        bus_read(A_ST, d);
        check_count++;
        if (d !== 32'h12) $display("FAIL ferr_status got=%h want=00000012", d); else pass_count++;
        bus_write(A_ST, 32'h08);
        bus_read(A_ST, d);
        check_count++;
        if (d !== 32'h12) $display("FAIL ferr_wrong_clear got=%h want=00000012", d); else pass_count++;
        bus_write(A_ST, 32'h10);
        bus_read(A_ST, d);
        check_count++;
        if (d !== 32'h2) $display("FAIL ferr_clear got=%h want=00000002", d); else pass_count++;
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        @(negedge clk); rx = 1'b0;
        @(negedge clk); rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        bus_read(A_ST, d);
        check_count++;
        if (d !== 32'h2) $display("FAIL glitch_status got=%h want=00000002", d); else pass_count++;
    endtask

    task automatic test_mid_reset();
        logic [31:0] d;
        int          lows;
        // TX: byte 0x00 keeps tx low through bit 3
        bus_write(A_TX, 32'h0);
        repeat (17) @(negedge clk);
        reset = 1'b1;
        #1;
        check_count++;
        if (tx !== 1'b1) $display("FAIL reset_tx_async got=%b want=1", tx); else pass_count++;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        lows = 0;
        repeat (12 * CPB) begin
            @(negedge clk);
            #1 if (tx !== 1'b1) lows++;
        end
        check_count++;
        if (lows != 0) $display("FAIL reset_tx_resume got=%0d low cycles want=0", lows); else pass_count++;
        bus_read(A_ST, d);
        check_count++;
        if (d !== 32'h2) $display("FAIL reset_tx_status got=%h want=00000002", d); else pass_count++;
        // RX: reset lands during data bit 5 of a 0x00 frame
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB + 5 * CPB + 2) @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (15 * CPB) @(negedge clk);
        bus_read(A_ST, d);
        check_count++;
        if (d !== 32'h2) $display("FAIL reset_rx_status got=%h want=00000002", d); else pass_count++;
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] e;
        logic [7:0]  b;
        logic        ok;
        logic [31:0] mask;
        for (int n = 0; n < 30; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) begin
                fork
                    run_tx_frame(8'($urandom), 1'b0);
                    send_rx_frame(b, ok, 1'b0, d);
                join
            end else begin
                send_rx_frame(b, ok, 1'b0, d);
            end
            if (!ok)                       m_ferr = 1'b1;
            else if (model_q.size() == 16) m_ovr = 1'b1;
            else                           model_q.push_back(b);
            if ($urandom_range(0, 2) == 0) begin
                bus_read(A_RX, d);
                e = (model_q.size() != 0) ? {24'h0, model_q.pop_front()} : 32'h0;
                check_count++;
                if (d !== e) $display("FAIL rand_pop[%0d] got=%h want=%h", n, d, e); else pass_count++;
            end
            if ($urandom_range(0, 3) == 0) begin
                mask = {27'h0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
                bus_write(A_ST, mask);
                if (mask[3]) m_ovr = 1'b0;
                if (mask[4]) m_ferr = 1'b0;
            end
            bus_read(A_ST, d);
            e = model_status();
            check_count++;
            if (d !== e) $display("FAIL rand_status[%0d] got=%h want=%h", n, d, e); else pass_count++;
        end
        while (model_q.size() != 0) begin
            bus_read(A_RX, d);
            e = {24'h0, model_q.pop_front()};
            check_count++;
            if (d !== e) $display("FAIL rand_drain got=%h want=%h", d, e); else pass_count++;
        end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_tx_drop();
        test_rx_roundtrip();
        test_overflow();
        test_push_pop_full();
        test_frame_err();
        test_glitch();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/uart_mmio.md
UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 10416; meaning: clock cycles per UART bit (100 MHz / 9600 baud).
REQ-002 The module SHALL have parameter BASE_ADDR, default 32'h0000_0400; meaning: base of the 16-byte register window.
REQ-003 The module SHALL have parameter RX_DEPTH, default 16; meaning: RX FIFO entries, a power of two.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 WE  input  2  store strobe from the datapath; 2'b00 = no store, any nonzero = store, data taken from WD[7:0].
REQ-007 RE  input  1  load strobe from the datapath; high during a load instruction.
REQ-008 ADDR  input  32  byte address of the access.
REQ-009 WD  input  32  store data.
REQ-010 RD  output  32  read data; combinational.
REQ-011 sel  output  1  combinational; high when ADDR[31:4] == BASE_ADDR[31:4].
REQ-012 tx  output  1  UART serial out; idle high.
REQ-013 rx  input  1  UART serial in; asynchronous to clk.

Function
REQ-014 Register map, offset = ADDR[3:0]:
- 0x0 TXDATA: write-only.
- 0x4 RXDATA: read pops the FIFO.
- 0x8 STATUS: read; write clears sticky flags.
- Other offsets: read 0, writes ignored.
REQ-015 STATUS bits: [0] tx_busy, [1] rx_empty, [2] rx_full, [3] overrun (sticky), [4] frame_err (sticky); [31:5] = 0.
REQ-016 RD SHALL be:
- RXDATA: {24'b0, FIFO head}, or 0 when the FIFO is empty.
- STATUS: the STATUS word.
- When sel is low: 0.
REQ-017 A store to TXDATA while tx_busy = 0 SHALL latch WD[7:0]; tx_busy SHALL read 1 from the next cycle on.
REQ-018 A store to TXDATA while tx_busy = 1 SHALL be dropped; the frame in flight SHALL be unaffected.
REQ-019 TX FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE -> START on an accepted TXDATA store.
- START drives 0 for CLKS_PER_BIT cycles.
- DATA sends bits 0..7, LSB first, CLKS_PER_BIT cycles each.
- STOP drives 1 for CLKS_PER_BIT cycles.
- STOP -> IDLE; tx_busy clears on that transition.
REQ-020 rx SHALL pass through a 2-flop synchronizer; the RX FSM SHALL see only the synchronized value.
REQ-021 RX FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE -> START on synchronized rx = 0.
- START re-samples after CLKS_PER_BIT/2 cycles: still 0 -> DATA; 1 -> IDLE (false start, nothing recorded).
- DATA samples 8 bits, one every CLKS_PER_BIT cycles, LSB first.
- STOP samples once after a further CLKS_PER_BIT cycles.
REQ-022 At the STOP sample: 1 SHALL push the byte into the FIFO; 0 SHALL discard the byte and set frame_err. Either way the FSM returns to IDLE.
REQ-023 A pop SHALL occur on the clk edge where RE = 1, sel = 1, offset = 0x4 and the FIFO is not empty; a pop from an empty FIFO SHALL have no effect.
REQ-024 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full; the count stays unchanged and no overrun is raised.
REQ-025 A push into a full FIFO without a simultaneous pop SHALL drop the new byte and set overrun; FIFO contents SHALL be unchanged.
REQ-026 FIFO pointers SHALL wrap modulo RX_DEPTH.
REQ-027 The count SHALL be log2(RX_DEPTH)+1 bits wide, so full and empty are distinguishable.
REQ-028 A store to STATUS SHALL clear overrun if WD[3] = 1 and clear frame_err if WD[4] = 1; a set event in the same cycle SHALL take priority over the clear.
REQ-029 TX and RX SHALL operate independently and concurrently.

Reset
REQ-030 While reset = 1, the module SHALL hold:
- both FSMs in IDLE;
- tx = 1;
- synchronizer flops at 1;
- FIFO empty, with pointers and count at 0;
- overrun, frame_err and tx_busy at 0;
- all baud counters at 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately; tx returns high asynchronously and no partial byte is pushed.

Structure
REQ-032 A shared package uart_pkg SHALL hold:
- the register offsets (0x0, 0x4, 0x8);
- the STATUS bit positions;
- the TX and RX FSM state enumerations.
REQ-033 The RX FIFO SHALL be a sub-module named uart_rx_fifo with push/pop/full/empty/overrun ports.
REQ-034 TX and RX SHALL remain in uart_mmio.

Verification (CLKS_PER_BIT = 4, BASE_ADDR = 0x400)
REQ-035 TX frame:
- Stimulus: store 0xA5 to 0x400.
- Required: tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles.
- STATUS[0] = 1 throughout the frame and 0 after it.
REQ-036 TX drop while busy:
- Stimulus: store 0x3C to 0x400 mid-frame.
- Required: the frame is unchanged and no second frame follows.
REQ-037 RX round trip:
- Stimulus: drive a valid 0x5A frame on rx.
- Required: STATUS[1] = 0; a load from 0x404 returns 0x0000005A; the next STATUS read has bit1 = 1.
REQ-038 Overflow:
- Stimulus: receive 17 frames with no loads.
- Required: STATUS = 0x0000000C (full, overrun); the 16 loads return the first 16 bytes.
- A store of 0x08 to 0x408 then clears overrun.
REQ-039 Framing error and false start:
- Frame with stop bit 0 -> STATUS[4] = 1 and the FIFO stays empty.
- A 1-cycle rx low glitch -> no push and no flag.
REQ-040 Mid-frame reset:
- Stimulus: assert reset during TX bit 3 and during RX bit 5.
- Required: tx = 1 immediately, STATUS = 0x00000002 after release, no spurious byte in the FIFO.
